// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_pkg
//  Purpose  : Shared types and defaults for the pipeline stage register
//             family: stage occupancy enum, default NOP/bubble payload and
//             default performance-counter width.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package pipe_pkg;

  // Stage occupancy. FULL is only reachable when the skid entry exists.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  // Widest supported payload; the default bubble is sliced from this.
  localparam int           PIPE_DATA_W_MAX = 256;
  localparam logic [255:0] PIPE_NOP_DEF    = '0;

  // Default width of the bubble performance counter.
  localparam int           PIPE_CNT_W_DEF  = 16;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_bubble_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_bubble_cnt
//  Purpose  : Saturating event counter with synchronous clear. Shared by the
//             pipeline performance counters.
//  Ports    : clk   in   rising-edge clock
//             reset in   asynchronous active-low reset, clears count
//             clr   in   synchronous clear, wins over inc
//             inc   in   count one event this cycle
//             cnt   out  CNT_W current count, sticks at all-ones
//  Revision : 1.0  initial release
// ============================================================================
module pipe_bubble_cnt
  import pipe_pkg::*;
#(
  parameter int CNT_W = PIPE_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != c_CNT_MAX)) begin
      r_cnt <= r_cnt + c_CNT_ONE;
    end
  end

  assign cnt = r_cnt;

endmodule : pipe_bubble_cnt
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_reg
//  Purpose  : Pipeline stage register with valid/ready handshake, priority
//             flush (bubble insertion), optional two-entry skid buffer and a
//             saturating bubble counter.
//  Config   : PIPE_STAGE_SKID_EN defined   -> two entries, registered in_ready
//             PIPE_STAGE_SKID_EN undefined -> one entry,
//                                             in_ready = !out_valid || out_ready
//  Ports    : clk        in   rising-edge clock
//             reset      in   asynchronous active-low reset
//             flush      in   kill all held entries (highest priority)
//             in_valid   in   upstream offers in_data
//             in_data    in   DATA_W upstream payload
//             in_ready   out  stage accepts a payload this cycle
//             out_valid  out  stage presents a valid payload
//             out_data   out  DATA_W payload, BUBBLE when out_valid=0
//             out_ready  in   downstream consumes out_data
//             cnt_clr    in   synchronous clear of bubble_cnt
//             bubble_cnt out  CNT_W saturating count of delivered bubbles
//  Revision : 1.0  initial release
// ============================================================================
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] BUBBLE = PIPE_NOP_DEF[DATA_W-1:0],
  parameter int                CNT_W  = PIPE_CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  bubble_cnt
);

  pipe_state_e       r_state;
  pipe_state_e       w_state_next;
  logic [DATA_W-1:0] r_main;
  logic              w_out_valid;
  logic              w_in_ready;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_main_from_in;

  assign w_in_xfer  = in_valid && w_in_ready;
  assign w_out_xfer = w_out_valid && out_ready;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic; flush overrides every transition
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) w_state_next = ST_BUSY;
        end
        ST_BUSY: begin
          if (w_out_xfer && !w_in_xfer) begin
            w_state_next = ST_EMPTY;
          end
`ifdef PIPE_STAGE_SKID_EN
          else if (w_in_xfer && !w_out_xfer) begin
            w_state_next = ST_FULL;
          end
`endif
        end
        ST_FULL: begin
          if (w_out_xfer) w_state_next = ST_BUSY;
        end
        default: w_state_next = ST_EMPTY;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output logic; the held payload is masked whenever nothing is valid
  // --------------------------------------------------------------------------
  always_comb begin
    w_out_valid = (r_state != ST_EMPTY);
    out_valid   = w_out_valid;
    out_data    = w_out_valid ? r_main : BUBBLE;
    in_ready    = w_in_ready;
  end

  // Main entry takes fresh input when it is free or being drained this cycle.
  // Loads are suppressed under flush since the entry is discarded anyway.
  assign w_main_from_in = !flush && w_in_xfer &&
                          ((r_state == ST_EMPTY) || w_out_xfer);

`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0] r_skid;
  logic              r_in_ready;
  logic              w_main_from_skid;
  logic              w_skid_load;

  assign w_main_from_skid = !flush && (r_state == ST_FULL) && w_out_xfer;
  assign w_skid_load      = !flush && (r_state == ST_BUSY) &&
                            w_in_xfer && !w_out_xfer;

  // in_ready comes straight from a flop so upstream never sees out_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_ready <= 1'b1;
    end else begin
      r_in_ready <= (w_state_next != ST_FULL);
    end
  end
  assign w_in_ready = r_in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_main <= BUBBLE;
      r_skid <= BUBBLE;
    end else begin
      if (w_main_from_skid) begin
        r_main <= r_skid;
      end else if (w_main_from_in) begin
        r_main <= in_data;
      end
      if (w_skid_load) begin
        r_skid <= in_data;
      end
    end
  end
`else
  assign w_in_ready = !w_out_valid || out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_main <= BUBBLE;
    end else if (w_main_from_in) begin
      r_main <= in_data;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Bubble counter: downstream was ready but got nothing
  // --------------------------------------------------------------------------
  pipe_bubble_cnt #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (!w_out_valid && out_ready),
    .cnt   (bubble_cnt)
  );

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_reg
//  Purpose  : Self-checking bench for pipe_stage_reg. Table of directed
//             vectors plus hand sequences for stall, skid (PIPE_STAGE_SKID_EN),
//             asynchronous reset and counter saturation (CNT_W=4 instance).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_stage_reg;

  localparam logic [31:0] c_NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        flush, in_valid, in_ready, out_valid, out_ready, cnt_clr;
  logic [31:0] in_data, out_data;
  logic [15:0] bubble_cnt;

  logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_cnt_clr;
  logic [7:0]  s_in_data, s_out_data;
  logic [3:0]  s_bubble_cnt;

  int n_cmp = 0;
  int n_err = 0;

  pipe_stage_reg #(
    .DATA_W (32),
    .BUBBLE (c_NOP),
    .CNT_W  (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .cnt_clr    (cnt_clr),
    .bubble_cnt (bubble_cnt)
  );

  pipe_stage_reg #(
    .DATA_W (8),
    .BUBBLE (8'h00),
    .CNT_W  (4)
  ) dut_small (
    .clk        (clk),
    .reset      (reset),
    .flush      (s_flush),
    .in_valid   (s_in_valid),
    .in_data    (s_in_data),
    .in_ready   (s_in_ready),
    .out_valid  (s_out_valid),
    .out_data   (s_out_data),
    .out_ready  (s_out_ready),
    .cnt_clr    (s_cnt_clr),
    .bubble_cnt (s_bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run time limit reached, got timeout, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic ordy,
                       input logic fl, input logic clr);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    cnt_clr   = clr;
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        fl;
    logic        clr;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl [17];

  initial begin
    // inputs applied this cycle | outputs expected this cycle (before the edge)
    tbl[0]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, c_NOP,        16'd0};
    tbl[1]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, c_NOP,        16'd1};
    tbl[2]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, c_NOP,        16'd2};
    tbl[3]  = '{1'b1, 32'h11,       1'b1, 1'b0, 1'b0, 1'b1, 1'b0, c_NOP,        16'd3};
    tbl[4]  = '{1'b1, 32'h22,       1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11,       16'd4};
    tbl[5]  = '{1'b1, 32'h33,       1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h22,       16'd4};
    tbl[6]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h33,       16'd4};
    tbl[7]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, c_NOP,        16'd4};
    tbl[8]  = '{1'b1, 32'h55,       1'b0, 1'b0, 1'b0, 1'b1, 1'b0, c_NOP,        16'd4};
    tbl[9]  = '{1'b1, 32'h66,       1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h55,       16'd4};
    tbl[10] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, c_NOP,        16'd4};
    tbl[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 1'b0, c_NOP,        16'd5};
    tbl[12] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, c_NOP,        16'd0};
    tbl[13] = '{1'b1, 32'hA5A55A5A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, c_NOP,        16'd0};
    tbl[14] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA5A55A5A, 16'd1};
    tbl[15] = '{1'b1, 32'h77,       1'b0, 1'b1, 1'b0, 1'b1, 1'b0, c_NOP,        16'd1};
    tbl[16] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, c_NOP,        16'd1};

    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = 8'h00;
    s_out_ready = 1'b0; s_cnt_clr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].fl, tbl[i].clr);
      #1;
      chk($sformatf("row%0d_in_ready", i),   {31'd0, in_ready},  {31'd0, tbl[i].e_ir});
      chk($sformatf("row%0d_out_valid", i),  {31'd0, out_valid}, {31'd0, tbl[i].e_ov});
      chk($sformatf("row%0d_out_data", i),   out_data,           tbl[i].e_od);
      chk($sformatf("row%0d_bubble_cnt", i), {16'd0, bubble_cnt}, {16'd0, tbl[i].e_cnt});
    end

`ifdef PIPE_STAGE_SKID_EN
    // ---------------- skid: downstream stalls after first beat ----------------
    @(negedge clk); drive(1'b1, 32'hA0, 1'b1, 1'b0, 1'b0);
    #1 chk("skid_a_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); drive(1'b1, 32'hA1, 1'b0, 1'b0, 1'b0);
    #1 chk("skid_b_out_data", out_data, 32'hA0);
    chk("skid_b_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); drive(1'b1, 32'hA2, 1'b0, 1'b0, 1'b0);
    #1 chk("skid_c_in_ready", {31'd0, in_ready}, 32'd0);
    chk("skid_c_out_data", out_data, 32'hA0);
    @(negedge clk); drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    #1 chk("skid_d_out_data", out_data, 32'hA0);
    chk("skid_d_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk); drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    #1 chk("skid_e_out_data", out_data, 32'hA1);
    chk("skid_e_out_valid", {31'd0, out_valid}, 32'd1);
    chk("skid_e_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1 chk("skid_f_out_valid", {31'd0, out_valid}, 32'd0);
    chk("skid_f_out_data", out_data, c_NOP);
    chk("skid_f_bubble_cnt", {16'd0, bubble_cnt}, 32'd2);
`else
    // ---------------- single entry: combinational in_ready under stall ----------------
    @(negedge clk); drive(1'b1, 32'h88, 1'b0, 1'b0, 1'b0);
    #1 chk("stall_a_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); drive(1'b1, 32'h99, 1'b0, 1'b0, 1'b0);
    #1 chk("stall_b_out_data", out_data, 32'h88);
    chk("stall_b_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk); drive(1'b1, 32'h99, 1'b0, 1'b0, 1'b0);
    #1 chk("stall_c_out_data_held", out_data, 32'h88);
    out_ready = 1'b1;
    #1 chk("stall_c_in_ready_comb", {31'd0, in_ready}, 32'd1);
    @(negedge clk); drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    #1 chk("stall_d_out_data", out_data, 32'h99);
    chk("stall_d_out_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk); drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1 chk("stall_e_out_valid", {31'd0, out_valid}, 32'd0);
    chk("stall_e_bubble_cnt", {16'd0, bubble_cnt}, 32'd1);
`endif

    // ---------------- asynchronous reset while holding entries ----------------
    @(negedge clk); drive(1'b1, 32'hC0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); drive(1'b1, 32'hC1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1 chk("arst_pre_out_valid", {31'd0, out_valid}, 32'd1);
    chk("arst_pre_in_ready", {31'd0, in_ready}, 32'd0);
    chk("arst_pre_out_data", out_data, 32'hC0);
    #1 reset = 1'b0;
    #1 chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_out_data", out_data, c_NOP);
    chk("arst_bubble_cnt", {16'd0, bubble_cnt}, 32'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    #1 chk("arst_post_out_valid", {31'd0, out_valid}, 32'd0);

    // ---------------- CNT_W=4 saturation and clear ----------------
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      s_out_ready = 1'b1;
      #1;
      if (i == 0 || i == 7 || i == 15 || i == 19)
        chk($sformatf("sat_cnt_i%0d", i), {28'd0, s_bubble_cnt},
            (i > 15) ? 32'd15 : i);
    end
    @(negedge clk); s_cnt_clr = 1'b1;
    #1 chk("sat_cnt_before_clr", {28'd0, s_bubble_cnt}, 32'd15);
    chk("sat_out_data_bubble", {24'd0, s_out_data}, 32'd0);
    @(negedge clk); s_cnt_clr = 1'b0; s_out_ready = 1'b0;
    #1 chk("sat_cnt_after_clr", {28'd0, s_bubble_cnt}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_pipe_stage_reg
`default_nettype wire
